// File: rtl/key_pkg.sv
// Shared types and helpers for the key input path (debouncer and click decoder).
// Tact math is kept here so both blocks derive their windows identically.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } click_state_t;

    function automatic int unsigned calc_tacts(input int unsigned clk_mhz,
                                               input int unsigned time_us);
        return clk_mhz * time_us;
    endfunction

endpackage

// File: rtl/key_click_decoder_if.sv
// Click event channel toward the control FSM: valid/ready plus event payload.
// master drives the event, slave returns ready.
interface key_click_decoder_if #(
    parameter int unsigned MAX_CLICKS = 3
) ();
    localparam int unsigned CW = $clog2(MAX_CLICKS + 1);

    logic          event_valid_o;
    logic          event_ready_i;
    logic [CW-1:0] event_clicks_o;
    logic          event_saturated_o;

    modport master (
        output event_valid_o,
        output event_clicks_o,
        output event_saturated_o,
        input  event_ready_i
    );

    modport slave (
        input  event_valid_o,
        input  event_clicks_o,
        input  event_saturated_o,
        output event_ready_i
    );

endinterface

// File: rtl/key_click_decoder_window_timer.sv
// Restartable up-counter; o_tc flags WINDOW_TACTS-1, combinationally from the count.
// No backpressure: clear has priority over enable, counter holds when disabled.
module window_timer #(
    parameter int unsigned WINDOW_TACTS = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);
    localparam int unsigned TW = (WINDOW_TACTS > 1) ? $clog2(WINDOW_TACTS) : 1;
    localparam logic [TW-1:0] TC_VAL = TW'(WINDOW_TACTS - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/key_click_decoder.sv
// Groups debounced press strobes into click events by inter-press timeout.
// Event valid WINDOW_TACTS+1 cycles after the last press; one-slot output, presses during a stall are dropped.
module key_click_decoder
    import key_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ = 50,
    parameter int unsigned WINDOW_US    = 300,
    parameter int unsigned MAX_CLICKS   = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   key_pressed_stb_i,
    key_click_decoder_if.master    evt_if,
    output logic                   busy_o,
    output logic                   drop_stb_o
);
    localparam int unsigned WINDOW_TACTS = calc_tacts(CLK_FREQ_MHZ, WINDOW_US);
    localparam int unsigned CW           = $clog2(MAX_CLICKS + 1);
    localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_CLICKS);

    click_state_t  r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sat;
    logic          r_valid;
    logic [CW-1:0] r_ev_clicks;
    logic          r_ev_sat;
    logic          r_busy;
    logic          r_drop;

    logic w_tc;
    logic w_hs;
    logic w_tmr_clear;
    logic w_tmr_en;

    // Timer only runs while collecting; any strobe restarts the window.
    assign w_tmr_en    = (r_state == COLLECT);
    assign w_tmr_clear = key_pressed_stb_i || (r_state != COLLECT);
    assign w_hs        = r_valid && evt_if.event_ready_i;

    window_timer #(
        .WINDOW_TACTS (WINDOW_TACTS)
    ) u_window_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_clear (w_tmr_clear),
        .i_en    (w_tmr_en),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_valid     <= 1'b0;
            r_ev_clicks <= '0;
            r_ev_sat    <= 1'b0;
            r_busy      <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (key_pressed_stb_i) begin
                        r_state <= COLLECT;
                        r_cnt   <= CW'(1);
                        r_sat   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                COLLECT: begin
                    // A strobe on the terminal-count cycle extends the sequence.
                    if (key_pressed_stb_i) begin
                        if (r_cnt < MAX_CNT) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_sat <= 1'b1;
                        end
                    end else if (w_tc) begin
                        r_state     <= EMIT;
                        r_valid     <= 1'b1;
                        r_ev_clicks <= r_cnt;
                        r_ev_sat    <= r_sat;
                    end
                end
                EMIT: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        if (key_pressed_stb_i) begin
                            r_state <= COLLECT;
                            r_cnt   <= CW'(1);
                            r_sat   <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (key_pressed_stb_i) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign evt_if.event_valid_o     = r_valid;
    assign evt_if.event_clicks_o    = r_ev_clicks;
    assign evt_if.event_saturated_o = r_ev_sat;
    assign busy_o                   = r_busy;
    assign drop_stb_o               = r_drop;

endmodule

// File: tb/tb_key_click_decoder.sv
// Bench for key_click_decoder with WINDOW_TACTS=4, MAX_CLICKS=3.
module tb_key_click_decoder;

    localparam int W  = 4;
    localparam int MC = 3;
    localparam int N  = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic stb   = 1'b0;
    logic busy;
    logic drop;

    int checks = 0;
    int errors = 0;

    bit       stb_tab [N];
    bit       rdy_tab [N];
    logic     ov [N];
    logic     ob [N];
    logic     od [N];
    logic     os [N];
    logic [1:0] oc [N];

    key_click_decoder_if #(.MAX_CLICKS(MC)) evt ();

    key_click_decoder #(
        .CLK_FREQ_MHZ (4),
        .WINDOW_US    (1),
        .MAX_CLICKS   (MC)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .key_pressed_stb_i (stb),
        .evt_if            (evt),
        .busy_o            (busy),
        .drop_stb_o        (drop)
    );

    always #5 clk = ~clk;

    task automatic clear_tabs();
        for (int t = 0; t < N; t++) begin
            stb_tab[t] = 1'b0;
            rdy_tab[t] = 1'b1;
        end
    endtask

    // Cycle t: outputs sampled 1ns after its opening edge, then inputs for cycle t applied.
    task automatic run_cycles(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
            ov[t] = evt.event_valid_o;
            oc[t] = evt.event_clicks_o;
            os[t] = evt.event_saturated_o;
            ob[t] = busy;
            od[t] = drop;
            stb = stb_tab[t];
            evt.event_ready_i = rdy_tab[t];
        end
        @(posedge clk); #1;
        stb = 1'b0;
        evt.event_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stb = 1'b0;
        evt.event_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (evt.event_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", evt.event_valid_o); end
        checks++; if (evt.event_clicks_o !== 2'd0) begin errors++; $display("FAIL reset_clicks got=%0d exp=0", evt.event_clicks_o); end
        checks++; if (evt.event_saturated_o !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b exp=0", evt.event_saturated_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam int SC_STB [5][5] = '{'{10, -1, -1, -1, -1}, '{10, 13, -1, -1, -1},
                                     '{10, 15, -1, -1, -1}, '{10, 12, 14, 16, 18},
                                     '{10, 14, -1, -1, -1}};
    localparam int SC_EV  [5][2] = '{'{15, -1}, '{18, -1}, '{15, 20}, '{23, -1}, '{19, -1}};
    localparam int SC_CLK [5]    = '{1, 2, 1, 3, 2};
    localparam int SC_SAT [5]    = '{0, 0, 0, 1, 0};
    localparam int SC_BHI [5]    = '{15, 18, 20, 23, 19};

    task automatic test_ready_tied();
        for (int s = 0; s < 5; s++) begin
            clear_tabs();
            for (int k = 0; k < 5; k++)
                if (SC_STB[s][k] >= 0) stb_tab[SC_STB[s][k]] = 1'b1;
            run_cycles(40);
            for (int t = 0; t < 40; t++) begin
                logic ev, eb;
                ev = (t == SC_EV[s][0]) || (t == SC_EV[s][1]);
                eb = (t >= 11) && (t <= SC_BHI[s]);
                checks++; if (ov[t] !== ev) begin errors++; $display("FAIL tied_valid sc=%0d cyc=%0d got=%b exp=%b", s, t, ov[t], ev); end
                checks++; if (ob[t] !== eb) begin errors++; $display("FAIL tied_busy sc=%0d cyc=%0d got=%b exp=%b", s, t, ob[t], eb); end
                checks++; if (od[t] !== 1'b0) begin errors++; $display("FAIL tied_drop sc=%0d cyc=%0d got=%b exp=0", s, t, od[t]); end
                if (ev) begin
                    checks++; if (oc[t] !== 2'(SC_CLK[s])) begin errors++; $display("FAIL tied_clicks sc=%0d cyc=%0d got=%0d exp=%0d", s, t, oc[t], SC_CLK[s]); end
                    checks++; if (os[t] !== 1'(SC_SAT[s])) begin errors++; $display("FAIL tied_sat sc=%0d cyc=%0d got=%b exp=%0d", s, t, os[t], SC_SAT[s]); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_tabs();
        for (int t = 0; t < 40; t++) rdy_tab[t] = (t == 25);
        stb_tab[10] = 1'b1;
        stb_tab[20] = 1'b1;
        run_cycles(40);
        for (int t = 0; t < 40; t++) begin
            logic ev, eb, ed;
            ev = (t >= 15) && (t <= 25);
            eb = (t >= 11) && (t <= 25);
            ed = (t == 21);
            checks++; if (ov[t] !== ev) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", t, ov[t], ev); end
            checks++; if (ob[t] !== eb) begin errors++; $display("FAIL bp_busy cyc=%0d got=%b exp=%b", t, ob[t], eb); end
            checks++; if (od[t] !== ed) begin errors++; $display("FAIL bp_drop cyc=%0d got=%b exp=%b", t, od[t], ed); end
            if (ev) begin
                checks++; if (oc[t] !== 2'd1) begin errors++; $display("FAIL bp_clicks cyc=%0d got=%0d exp=1", t, oc[t]); end
                checks++; if (os[t] !== 1'b0) begin errors++; $display("FAIL bp_sat cyc=%0d got=%b exp=0", t, os[t]); end
            end
        end
    endtask

    task automatic test_handshake_strobe();
        clear_tabs();
        for (int t = 0; t < 17; t++) rdy_tab[t] = 1'b0;
        stb_tab[10] = 1'b1;
        stb_tab[17] = 1'b1;
        run_cycles(40);
        for (int t = 0; t < 40; t++) begin
            logic ev, eb;
            ev = ((t >= 15) && (t <= 17)) || (t == 22);
            eb = (t >= 11) && (t <= 22);
            checks++; if (ov[t] !== ev) begin errors++; $display("FAIL hs_valid cyc=%0d got=%b exp=%b", t, ov[t], ev); end
            checks++; if (ob[t] !== eb) begin errors++; $display("FAIL hs_busy cyc=%0d got=%b exp=%b", t, ob[t], eb); end
            checks++; if (od[t] !== 1'b0) begin errors++; $display("FAIL hs_drop cyc=%0d got=%b exp=0", t, od[t]); end
            if (ev) begin
                checks++; if (oc[t] !== 2'd1) begin errors++; $display("FAIL hs_clicks cyc=%0d got=%0d exp=1", t, oc[t]); end
            end
        end
    endtask

    // Reference: presses closer than W+1 cycles share a sequence; with ready high the
    // event shows for the single cycle last+W+1 and busy spans first+1 .. that cycle.
    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int q[$];
            logic     ev_e [N];
            logic     eb_e [N];
            int       ec_e [N];
            logic     es_e [N];
            int i;
            clear_tabs();
            for (int t = 0; t < N; t++) begin
                ev_e[t] = 1'b0; eb_e[t] = 1'b0; ec_e[t] = 0; es_e[t] = 1'b0;
            end
            for (int t = 2; t < N - 12; t++) begin
                stb_tab[t] = ($urandom_range(0, r + 1) == 0);
                if (stb_tab[t]) q.push_back(t);
            end
            i = 0;
            while (i < q.size()) begin
                int first, last, n, ev;
                first = q[i]; last = first; n = 1; i++;
                while (i < q.size() && (q[i] - last) <= W) begin
                    last = q[i]; n++; i++;
                end
                ev = last + W + 1;
                ev_e[ev] = 1'b1;
                ec_e[ev] = (n > MC) ? MC : n;
                es_e[ev] = (n > MC);
                for (int b = first + 1; b <= ev; b++) eb_e[b] = 1'b1;
            end
            run_cycles(N);
            for (int t = 0; t < N; t++) begin
                checks++; if (ov[t] !== ev_e[t]) begin errors++; $display("FAIL rnd_valid r=%0d cyc=%0d got=%b exp=%b", r, t, ov[t], ev_e[t]); end
                checks++; if (ob[t] !== eb_e[t]) begin errors++; $display("FAIL rnd_busy r=%0d cyc=%0d got=%b exp=%b", r, t, ob[t], eb_e[t]); end
                checks++; if (od[t] !== 1'b0) begin errors++; $display("FAIL rnd_drop r=%0d cyc=%0d got=%b exp=0", r, t, od[t]); end
                if (ev_e[t]) begin
                    checks++; if (oc[t] !== 2'(ec_e[t])) begin errors++; $display("FAIL rnd_clicks r=%0d cyc=%0d got=%0d exp=%0d", r, t, oc[t], ec_e[t]); end
                    checks++; if (os[t] !== es_e[t]) begin errors++; $display("FAIL rnd_sat r=%0d cyc=%0d got=%b exp=%b", r, t, os[t], es_e[t]); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_collect();
        evt.event_ready_i = 1'b1;
        @(posedge clk); #1; stb = 1'b1;
        @(posedge clk); #1; stb = 1'b0;
        @(posedge clk); #1; stb = 1'b1;
        @(posedge clk); #1; stb = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got=%b exp=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_rst got=%b exp=0", busy); end
        checks++; if (evt.event_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid_rst got=%b exp=0", evt.event_valid_o); end
        checks++; if (evt.event_clicks_o !== 2'd0) begin errors++; $display("FAIL mid_clicks_rst got=%0d exp=0", evt.event_clicks_o); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL mid_drop_rst got=%b exp=0", drop); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            checks++; if (evt.event_valid_o !== 1'b0) begin errors++; $display("FAIL mid_post_valid cyc=%0d got=%b exp=0", t, evt.event_valid_o); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_post_busy cyc=%0d got=%b exp=0", t, busy); end
        end
    endtask

    task automatic test_reset_in_emit();
        @(posedge clk); #1; stb = 1'b1; evt.event_ready_i = 1'b0;
        @(posedge clk); #1; stb = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        checks++; if (evt.event_valid_o !== 1'b1) begin errors++; $display("FAIL emit_valid_pre got=%b exp=1", evt.event_valid_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (evt.event_valid_o !== 1'b0) begin errors++; $display("FAIL emit_valid_rst got=%b exp=0", evt.event_valid_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL emit_busy_rst got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        evt.event_ready_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (evt.event_valid_o !== 1'b0) begin errors++; $display("FAIL emit_post_valid got=%b exp=0", evt.event_valid_o); end
    endtask

    initial begin
        evt.event_ready_i = 1'b1;
        test_reset();
        test_ready_tied();
        test_backpressure();
        test_handshake_strobe();
        test_random();
        test_reset_mid_collect();
        test_reset_in_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_click_decoder.md
# key_click_decoder

Consumes the one-cycle press strobe from the key debouncer and groups presses into click events (single, double, triple, …) by inter-press timeout. Emits one event per completed sequence on a valid/ready interface toward the control FSM. Presses are counted up to a saturation limit. Strobes that arrive while an event is stalled are reported as dropped.

## Interface
- `CLK_FREQ_MHZ`, default 50: clock frequency in MHz.
- `WINDOW_US`, default 300: maximum gap between presses in one sequence, in µs.
- `MAX_CLICKS`, default 3: saturation limit of the click count; must be ≥ 2.
- `clk_i`  in  1  system clock; single clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `key_pressed_stb_i`  in  1  one-cycle press strobe, synchronous to `clk_i`.
- `event_valid_o`  out  1  completed click event available.
- `event_ready_i`  in  1  consumer accepts the event.
- `event_clicks_o`  out  `$clog2(MAX_CLICKS+1)`  number of presses in the sequence, 1..MAX_CLICKS.
- `event_saturated_o`  out  1  more than MAX_CLICKS presses were seen in the sequence.
- `busy_o`  out  1  a sequence is being collected or an event is pending.
- `drop_stb_o`  out  1  one-cycle pulse: a press was discarded.

## Operation
- Derived constant `WINDOW_TACTS = WINDOW_US * CLK_FREQ_MHZ`, which must be ≥ 2.
  - Timer width is `$clog2(WINDOW_TACTS)`.
  - Counter width is `$clog2(MAX_CLICKS+1)`.
- All outputs are registered. On reset every output is 0, the state is IDLE, and the counter and timer are cleared.
- FSM states: IDLE, COLLECT, EMIT.
- IDLE:
  - Strobe → COLLECT, count = 1, timer = 0, saturated flag = 0.
- COLLECT:
  - Timer increments each cycle.
  - Strobe → timer = 0. If count < MAX_CLICKS, count is incremented; otherwise count holds and the saturated flag is set.
  - Timer == WINDOW_TACTS−1 with no strobe → EMIT. The count and saturated flag are loaded into the event outputs.
  - Strobe in the same cycle as the timeout: the strobe wins, the sequence continues and the timer restarts.
- EMIT:
  - `event_valid_o` = 1. `event_clicks_o` and `event_saturated_o` are held stable until the handshake.
  - `event_valid_o` && `event_ready_i` → IDLE; valid is low the next cycle.
  - Strobe in the handshake cycle → COLLECT with count = 1. Nothing is dropped.
  - Strobe without a handshake → strobe discarded, `drop_stb_o` = 1 in the next cycle. The event is unchanged.
- `busy_o` = 1 in COLLECT and EMIT.
- Reset asserted mid-sequence: the sequence is discarded and no event is produced after reset releases.

## Timing
- Strobe sampled in cycle c. Cycle c+k sees timer = k−1.
- The last strobe in cycle c gives `event_valid_o` high from cycle c+WINDOW_TACTS+1.
- `busy_o` rises in cycle c+1 after the first strobe.
- Handshake in cycle h gives `event_valid_o` = 0 and `busy_o` = 0 in cycle h+1, unless a strobe was accepted in cycle h.
- `drop_stb_o` is high for exactly 1 cycle, in d+1 for a strobe discarded in cycle d.
- Back-to-back strobes in consecutive cycles are each counted.
- Throughput: at most one event per sequence; there is no buffering beyond the single EMIT slot.

## Structure
- Shared package `key_pkg`:
  - State typedef `click_state_t` (IDLE, COLLECT, EMIT).
  - Function computing `WINDOW_TACTS` from MHz and µs; shared with the debouncer's tact calculation.
- One small sub-module, `window_timer`: a restartable up-counter with clear input and terminal-count output at WINDOW_TACTS−1.
- FSM and output registers live in `key_click_decoder`.

## Test plan
Benches use CLK_FREQ_MHZ=4, WINDOW_US=1 (WINDOW_TACTS=4) and MAX_CLICKS=3.
- Single strobe in cycle 10, ready tied 1 → valid high in cycle 15 only, clicks=1, saturated=0, `busy_o` high in cycles 11–15.
- Strobes in cycles 10 and 13 → valid in cycle 18, clicks=2. Strobes in cycles 10 and 15 → two events with clicks=1 each, valid in cycles 15 and 20.
- Five strobes in cycles 10, 12, 14, 16, 18 → one event in cycle 23, clicks=3, saturated=1.
- Backpressure:
  - Ready=0, event pending from cycle 15, strobe in cycle 20 → `drop_stb_o` high in cycle 21 only; clicks unchanged.
  - Ready=1 in cycle 25 → valid=0 and busy=0 in cycle 26.
- Strobe in the handshake cycle → valid drops next cycle, busy stays 1, new event with clicks=1 appears WINDOW_TACTS+1 cycles later. Strobe coinciding with the timer terminal count extends the sequence: no event, count increments.
- Reset:
  - `rst_ni` low asynchronously mid-COLLECT (count=2) → all outputs 0 before the next edge; no event after release.
  - Reset during EMIT → valid clears immediately.
